fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the LEGv8 core; sits directly upstream of the combinational instruction ROM `imem`.
- Holds the program counter and drives the word address into `imem`.
- Captures the returned instruction into an IF/ID pipeline register, with support for stall, flush and branch redirect.
- Downstream, the decode stage consumes `if_id_*`.

Parameters:
- N, 64, PC / branch-target width.
- IW, 32, instruction width; matches imem N.
- AW, 8, imem word-address width; 256 words = 1 KiB.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset; sampled on rising edge of clk.
- stall  in  1  hold PC and IF/ID (hazard from decode).
- flush  in  1  insert bubble into IF/ID.
- pc_src  in  1  branch taken; redirect PC.
- pc_branch  in  N  branch target byte address.
- imem_q  in  IW  instruction returned by imem.
- imem_addr  out  AW  word address to imem.
- pc  out  N  current fetch PC.
- if_id_pc  out  N  PC of the instruction held in IF/ID.
- if_id_instr  out  IW  instruction held in IF/ID.
- if_id_valid  out  1  IF/ID holds a real instruction.
- halted  out  1  fetch stopped on the halt idiom; constant 0 when the feature is compiled out.

Behaviour:
- imem_addr = pc[AW+1:2], combinational. imem is combinational, so imem_q is valid in the same cycle.
- Reset (reset==0 at the edge): pc=0, if_id_pc=0, if_id_instr=0, if_id_valid=0, halted=0.
  - Reset overrides every other input.
  - Reset mid-operation discards IF/ID contents with no partial update.
- Per-edge priority, when reset==1: pc_src > flush > stall > normal.
- Normal (no stall/flush/pc_src):
  - pc <= pc+4, modulo 2^N.
  - if_id_pc <= pc; if_id_instr <= imem_q; if_id_valid <= 1.
- stall only: pc and all if_id_* hold.
- flush (pc_src=0):
  - if_id_instr <= 0, if_id_valid <= 0, if_id_pc <= pc.
  - pc <= pc+4 if stall=0; pc holds if stall=1.
- pc_src=1, regardless of stall/flush:
  - pc <= {pc_branch[N-1:2],2'b00}; bits [1:0] are ignored and forced to zero.
  - IF/ID is flushed (instr 0, valid 0), killing the wrong-path fetch.
- Latency: instruction at PC p appears on if_id_* one edge after pc==p, given no stall.
- Wrap-around:
  - imem_addr uses only pc[AW+1:2], so pc=0x400 addresses word 0.
  - pc itself keeps counting to N bits.
- Outputs are registered except imem_addr, which is a decode of the pc register.

Optional Feature:
- Macro FETCH_HALT_DETECT_EN.
- When defined:
  - If imem_q == HALT_INSTR (32'hB400001F, CBZ XZR,#0) is captured in a normal cycle, IF/ID takes it with valid=1 and halted <= 1 at the same edge.
  - pc does not advance on that edge.
  - While halted=1: pc holds, and if_id_valid <= 0 each subsequent edge (if_id_instr/pc hold).
  - stall, flush and pc_src are ignored while halted; only reset clears halted.
  - If pc_src or flush coincides with the halt fetch, the redirect/flush wins and no halt occurs.
- When undefined: no comparison logic; halted tied to 0; the halt instruction is fetched like any other.

Decomposition:
- Package fetch_pkg holds:
  - INSTR_W=32 and PC_STEP=4.
  - BUBBLE_INSTR=32'h00000000.
  - HALT_INSTR=32'hB400001F.
  - The packed struct if_id_t {pc, instr, valid}.
- One sub-module, if_id_reg: IF/ID register with load/hold/bubble control and synchronous active-low reset.
- PC logic and priority decode stay in fetch_stage.

Test Plan (ROM loaded with the team's lab program: word0=D29FFFE1, word1=F8000001, word4=F8400002, word7=B400001F):
- Reset sequencing: hold reset=0 for 2 edges, then release → first edge sees if_id_pc=0, if_id_instr=D29FFFE1, valid=1, pc=4; next edge gives if_id_pc=4, instr=F8000001, pc=8.
- Stall: assert stall for 2 edges at pc=8 → pc=8, imem_addr=2, if_id_pc=4/F8000001 held; on release, if_id_pc=8 and pc=0xC.
- Redirect over stall: stall=1, pc_src=1, pc_branch=0x13 → pc=0x10, valid=0, instr=0; next edge gives if_id_pc=0x10, instr=F8400002.
- Flush only, at pc=4 → if_id_valid=0, if_id_instr=0, pc=8; the following edge is normal.
- Wrap: redirect to 0x3FC → imem_addr=255; next edge gives pc=0x400, imem_addr=0; synchronous reset asserted mid-run clears all outputs on that edge.
- With FETCH_HALT_DETECT_EN defined: run from reset to pc=0x1C → if_id_instr=B400001F, valid=1, halted=1, pc stays 0x1C; next edge gives valid=0; pc_src pulse is ignored; reset clears halted.
- With FETCH_HALT_DETECT_EN undefined: same run → halted stays 0 and pc advances to 0x20.

Source files
------------

// File: rtl/fetch_stage_pkg.sv
// Shared types and constants for the LEGv8 fetch stage.
// Also holds HALT_INSTR, which fetch_stage uses when FETCH_HALT_DETECT_EN is defined.
package fetch_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;

    localparam logic [PC_W-1:0]    PC_STEP      = 64'd4;
    localparam logic [INSTR_W-1:0] BUBBLE_INSTR = 32'h0000_0000;
    localparam logic [INSTR_W-1:0] HALT_INSTR   = 32'hB400_001F;   // CBZ XZR,#0

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic               valid;
    } if_id_t;

    typedef enum logic [1:0] {
        IF_ID_LOAD   = 2'd0,
        IF_ID_HOLD   = 2'd1,
        IF_ID_BUBBLE = 2'd2,
        IF_ID_DROP   = 2'd3
    } if_id_op_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: control inputs, imem port and IF/ID outputs.
// master = fetch_stage, slave = decode/imem side.
interface fetch_stage_if #(
    parameter int N  = 64,
    parameter int IW = 32,
    parameter int AW = 8
);
    logic          stall;
    logic          flush;
    logic          pc_src;
    logic [N-1:0]  pc_branch;
    logic [IW-1:0] imem_q;
    logic [AW-1:0] imem_addr;
    logic [N-1:0]  pc;
    logic [N-1:0]  if_id_pc;
    logic [IW-1:0] if_id_instr;
    logic          if_id_valid;
    logic          halted;

    modport master (
        input  stall, flush, pc_src, pc_branch, imem_q,
        output imem_addr, pc, if_id_pc, if_id_instr, if_id_valid, halted
    );

    modport slave (
        output stall, flush, pc_src, pc_branch, imem_q,
        input  imem_addr, pc, if_id_pc, if_id_instr, if_id_valid, halted
    );
endinterface

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register: load, hold, bubble (zero instr, keep pc) or drop valid only.
// Synchronous active-low reset.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  if_id_op_t op,
    input  if_id_t    d,
    output if_id_t    q
);

    always_ff @(posedge clk) begin
        if (!reset) begin
            q <= '0;
        end else begin
            case (op)
                IF_ID_LOAD:   q <= d;
                IF_ID_HOLD:   q <= q;
                IF_ID_BUBBLE: begin
                    q.pc    <= d.pc;
                    q.instr <= BUBBLE_INSTR;
                    q.valid <= 1'b0;
                end
                IF_ID_DROP:   q.valid <= 1'b0;
                default:      q <= q;
            endcase
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch: PC register, imem word address and IF/ID control.
// Optional halt-idiom detection under FETCH_HALT_DETECT_EN.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int N  = 64,
    parameter int IW = 32,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          reset,
    fetch_stage_if.master bus
);

    logic [N-1:0] pc_r;
    logic [N-1:0] pc_inc;
    logic [N-1:0] pc_tgt;
    logic         normal;
    logic         halted_r;
    logic         halt_hit;
    if_id_op_t    op;
    if_id_t       d;
    if_id_t       q;

    assign pc_inc = pc_r + N'(PC_STEP);
    assign pc_tgt = bus.pc_branch & ~N'(3);
    assign normal = !bus.pc_src && !bus.flush && !bus.stall;

`ifdef FETCH_HALT_DETECT_EN
    assign halt_hit = normal && (bus.imem_q == IW'(HALT_INSTR));

    always_ff @(posedge clk) begin
        if (!reset) begin
            halted_r <= 1'b0;
        end else if (!halted_r && halt_hit) begin
            halted_r <= 1'b1;
        end
    end
`else
    assign halt_hit = 1'b0;
    assign halted_r = 1'b0;
`endif

    // pc_src > flush > stall > normal; a halted core freezes until reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_r <= '0;
        end else if (halted_r) begin
            pc_r <= pc_r;
        end else if (bus.pc_src) begin
            pc_r <= pc_tgt;
        end else if (bus.flush) begin
            pc_r <= bus.stall ? pc_r : pc_inc;
        end else if (!bus.stall && !halt_hit) begin
            pc_r <= pc_inc;
        end
    end

    always_comb begin
        op = IF_ID_LOAD;
        if (halted_r) begin
            op = IF_ID_DROP;
        end else if (bus.pc_src || bus.flush) begin
            op = IF_ID_BUBBLE;
        end else if (bus.stall) begin
            op = IF_ID_HOLD;
        end
    end

    always_comb begin
        d       = '0;
        d.pc    = PC_W'(pc_r);
        d.instr = INSTR_W'(bus.imem_q);
        d.valid = 1'b1;
    end

    if_id_reg u_if_id_reg (
        .clk   (clk),
        .reset (reset),
        .op    (op),
        .d     (d),
        .q     (q)
    );

    assign bus.imem_addr   = pc_r[AW+1:2];
    assign bus.pc          = pc_r;
    assign bus.if_id_pc    = N'(q.pc);
    assign bus.if_id_instr = IW'(q.instr);
    assign bus.if_id_valid = q.valid;
    assign bus.halted      = halted_r;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed lab-program scenarios plus
// randomized control traffic against a behavioural fetch model.
module tb_fetch_stage;
    import fetch_pkg::*;

`ifdef FETCH_HALT_DETECT_EN
    localparam bit HALT_EN = 1'b1;
`else
    localparam bit HALT_EN = 1'b0;
`endif

    typedef logic [169:0] snap_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    fetch_stage_if #(.N(64), .IW(32), .AW(8)) bus ();

    fetch_stage #(.N(64), .IW(32), .AW(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0] rom [256];
    assign bus.imem_q = rom[bus.imem_addr];

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] m_pc, m_ifpc;
    logic [31:0] m_instr;
    logic        m_valid, m_halted;

    function automatic snap_t got();
        return {bus.pc, bus.if_id_pc, bus.if_id_instr, bus.if_id_valid, bus.halted, bus.imem_addr};
    endfunction

    function automatic snap_t want(input logic [63:0] p, input logic [63:0] ip,
                                   input logic [31:0] ins, input logic v, input logic h);
        logic [7:0] word;
        word = 8'((p / 4) % 256);
        return {p, ip, ins, v, h, word};
    endfunction

    // Drive one cycle of inputs and advance the reference model by one edge.
    task automatic cyc(input logic r, input logic st, input logic fl, input logic ps,
                       input logic [63:0] br);
        @(negedge clk);
        reset         = r;
        bus.stall     = st;
        bus.flush     = fl;
        bus.pc_src    = ps;
        bus.pc_branch = br;
        if (!r) begin
            m_pc = 0; m_ifpc = 0; m_instr = 0; m_valid = 0; m_halted = 0;
        end else if (m_halted) begin
            m_valid = 0;
        end else if (ps) begin
            m_ifpc = m_pc; m_instr = 0; m_valid = 0;
            m_pc = br - (br % 4);
        end else if (fl) begin
            m_ifpc = m_pc; m_instr = 0; m_valid = 0;
            if (!st) m_pc = m_pc + 4;
        end else if (!st) begin
            m_ifpc  = m_pc;
            m_instr = rom[(m_pc / 4) % 256];
            m_valid = 1;
            if (HALT_EN && m_instr == 32'hB400001F) m_halted = 1;
            else m_pc = m_pc + 4;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        snap_t e;
        cyc(0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 64'h55);
        e = want(0, 0, 0, 0, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL reset: got %h want %h", got(), e); end
    endtask

    task automatic test_sequence();
        snap_t e;
        cyc(1, 0, 0, 0, 0);
        e = want(64'h4, 64'h0, 32'hD29FFFE1, 1, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL release1: got %h want %h", got(), e); end
        cyc(1, 0, 0, 0, 0);
        e = want(64'h8, 64'h4, 32'hF8000001, 1, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL release2: got %h want %h", got(), e); end
        for (int i = 0; i < 2; i++) begin
            cyc(1, 1, 0, 0, 0);
            e = want(64'h8, 64'h4, 32'hF8000001, 1, 0);
            n_vec++;
            if (got() !== e) begin n_err++; $display("FAIL stall_hold%0d: got %h want %h", i, got(), e); end
        end
        cyc(1, 0, 0, 0, 0);
        e = want(64'hC, 64'h8, rom[2], 1, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL stall_release: got %h want %h", got(), e); end
        cyc(1, 1, 0, 1, 64'h13);
        e = want(64'h10, 64'hC, 0, 0, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL redirect_over_stall: got %h want %h", got(), e); end
        cyc(1, 0, 0, 0, 0);
        e = want(64'h14, 64'h10, 32'hF8400002, 1, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL redirect_target: got %h want %h", got(), e); end
        cyc(1, 0, 0, 1, 64'h4);
        cyc(1, 0, 1, 0, 0);
        e = want(64'h8, 64'h4, 0, 0, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL flush: got %h want %h", got(), e); end
        cyc(1, 0, 0, 0, 0);
        e = want(64'hC, 64'h8, rom[2], 1, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL after_flush: got %h want %h", got(), e); end
        cyc(1, 0, 0, 1, 64'h3FC);
        e = want(64'h3FC, 64'hC, 0, 0, 0);
        n_vec++;
        if (got() !== e || bus.imem_addr !== 8'd255) begin
            n_err++; $display("FAIL wrap_redirect: got %h want %h", got(), e);
        end
        cyc(1, 0, 0, 0, 0);
        e = want(64'h400, 64'h3FC, rom[255], 1, 0);
        n_vec++;
        if (got() !== e || bus.imem_addr !== 8'd0) begin
            n_err++; $display("FAIL wrap_pc400: got %h want %h", got(), e);
        end
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);
        e = want(0, 0, 0, 0, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL mid_reset: got %h want %h", got(), e); end
    endtask

    task automatic test_halt();
        snap_t e;
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0);
        e = want(64'h1C, 64'h18, rom[6], 1, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL reach_1c: got %h want %h", got(), e); end
        cyc(1, 0, 0, 0, 0);
`ifdef FETCH_HALT_DETECT_EN
        e = want(64'h1C, 64'h1C, 32'hB400001F, 1, 1);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL halt_capture: got %h want %h", got(), e); end
        cyc(1, 0, 0, 1, 64'h40);
        e = want(64'h1C, 64'h1C, 32'hB400001F, 0, 1);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL halt_ignore_redirect: got %h want %h", got(), e); end
        cyc(1, 1, 1, 0, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL halt_ignore_flush: got %h want %h", got(), e); end
        cyc(0, 0, 0, 0, 0);
        e = want(0, 0, 0, 0, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL halt_reset: got %h want %h", got(), e); end
`else
        e = want(64'h20, 64'h1C, 32'hB400001F, 1, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL no_halt: got %h want %h", got(), e); end
        cyc(1, 0, 0, 0, 0);
        e = want(64'h24, 64'h20, rom[8], 1, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL no_halt_next: got %h want %h", got(), e); end
`endif
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) cyc(1, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 0);
        e = want(64'h20, 64'h1C, 0, 0, 0);
        n_vec++;
        if (got() !== e) begin n_err++; $display("FAIL flush_beats_halt: got %h want %h", got(), e); end
    endtask

    task automatic test_random();
        snap_t       e;
        logic        r, st, fl, ps;
        logic [63:0] br;
        cyc(0, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom_range(0, 49) != 0);
            st = ($urandom_range(0, 3) == 0);
            fl = ($urandom_range(0, 9) == 0);
            ps = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 7))
                0:       br = {$urandom, $urandom};
                1:       br = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
                default: br = 64'($urandom_range(0, 127));
            endcase
            cyc(r, st, fl, ps, br);
            e = want(m_pc, m_ifpc, m_instr, m_valid, m_halted);
            n_vec++;
            if (got() !== e) begin
                n_err++;
                $display("FAIL random[%0d]: got %h want %h", i, got(), e);
            end
        end
    endtask

    initial begin
        logic [31:0] w;
        reset = 1'b0;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        bus.pc_src = 1'b0;
        bus.pc_branch = '0;
        m_pc = 0; m_ifpc = 0; m_instr = 0; m_valid = 0; m_halted = 0;
        for (int i = 0; i < 256; i++) begin
            do w = $urandom; while (w == 32'hB400001F);
            rom[i] = w;
        end
        rom[0] = 32'hD29FFFE1;
        rom[1] = 32'hF8000001;
        rom[4] = 32'hF8400002;
        rom[7] = 32'hB400001F;

        test_reset();
        test_sequence();
        test_halt();
        test_random();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
